// File: rtl/tblac_pipe_if.sv
// Handshake bundle for the truncated binary-antilog pipeline.
// The log sum comes in on one side and the linear product goes out on the other.
interface tblac_pipe_if #(
    parameter int F = 5
) ();
    logic         in_valid;
    logic         in_ready;
    logic         in_zero;
    logic [4:0]   in_k;
    logic [F-1:0] in_f;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_p;

    modport master (
        output in_valid, in_zero, in_k, in_f, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_zero, in_k, in_f, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/tblac_pipe.sv
// Two-stage truncated binary-antilog converter.
// Rebuilds P = (1.f) * 2^k from a summed log value {k, f}.
module tblac_pipe #(
    parameter int F    = 5,
    parameter int COMP = 1
) (
    input logic         clk,
    input logic         rst_n,
    tblac_pipe_if.slave bus
);
    localparam int W = F + 1 + ((COMP != 0) ? 1 : 0);
    localparam logic signed [5:0] SOFF = 6'(W - 1);

    logic                s1_valid;
    logic                s1_zero;
    logic [W-1:0]        s1_m;
    logic signed [5:0]   s1_s;
    logic                s1_left;
    logic                s2_valid;
    logic [31:0]         s2_p;

    logic                s1_adv;
    logic                s2_adv;
    logic [W-1:0]        m_in;
    logic signed [5:0]   s_in;
    logic [31:0]         m_ext;
    logic [5:0]          s_neg;
    logic [31:0]         p_nxt;

    if (COMP != 0) begin : g_comp
        assign m_in = {1'b1, bus.in_f, 1'b1};
    end else begin : g_nocomp
        assign m_in = {1'b1, bus.in_f};
    end

    assign s_in = $signed({1'b0, bus.in_k}) - SOFF;

    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_p     = s2_p;

    assign m_ext = {{(32 - W){1'b0}}, s1_m};
    assign s_neg = 6'(-s1_s);

    // Shift the mantissa into place; right shifts simply drop low bits.
    always_comb begin
        p_nxt = '0;
        if (s1_zero)
            p_nxt = '0;
        else if (s1_left)
            p_nxt = m_ext << s1_s[4:0];
        else
            p_nxt = m_ext >> s_neg;
    end

    // Stage 1: latch zero flag, mantissa and precomputed shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_m     <= '0;
            s1_s     <= '0;
            s1_left  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_zero <= bus.in_zero;
                s1_m    <= m_in;
                s1_s    <= s_in;
                s1_left <= !s_in[5];
            end
        end
    end

    // Stage 2: register the product; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_p     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_p <= p_nxt;
        end
    end
endmodule

// File: tb/tb_tblac_pipe.sv
// Bench for the antilog pipeline.
// Scoreboard queues hold expected products and acceptance cycles.
module tb_tblac_pipe;
    typedef struct {
        logic [31:0] p;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tblac_pipe_if #(.F(5)) a ();
    tblac_pipe_if #(.F(5)) b ();

    tblac_pipe #(.F(5), .COMP(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a)
    );

    tblac_pipe #(.F(5), .COMP(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;

    exp_t        qa[$];
    exp_t        qb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] a_exp = '0;
    logic [31:0] b_exp = '0;
    logic        acc = 1'b0;
    logic        rdy = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_p = '0;
    logic        chk_lat = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(int comp, logic z,
                                          logic [4:0] k,
                                          logic [4:0] f);
        logic [31:0] m;
        int          s;
        m = 32'h20 | 32'(f);
        if (comp != 0)
            m = (m << 1) | 32'h1;
        s = int'(k) - ((comp != 0) ? 6 : 5);
        if (z)
            return 32'h0;
        if (s >= 0)
            return m << s;
        return m >> (-s);
    endfunction

    task automatic put_a(logic z, logic [4:0] k, logic [4:0] f,
                         logic [31:0] e);
        a.in_valid = 1'b1;
        a.in_zero  = z;
        a.in_k     = k;
        a.in_f     = f;
        a_exp      = e;
    endtask

    task automatic put_b(logic [4:0] k, logic [4:0] f, logic [31:0] e);
        b.in_valid = 1'b1;
        b.in_zero  = 1'b0;
        b.in_k     = k;
        b.in_f     = f;
        b_exp      = e;
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        rdy = a.in_ready;
        acc = a.in_valid && rdy;
        if (acc)
            qa.push_back('{a_exp, cyc});
        if (stall_prev) begin
            chk("hold_valid", 32'(a.out_valid), 32'd1);
            chk("hold_p", a.out_p, prev_p);
        end
        if (a.out_valid && a.out_ready) begin
            n_cmp++;
            assert (qa.size() != 0)
            else begin
                n_bad++;
                $error("FAIL spurious_a obs=%h exp=none", a.out_p);
            end
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("data_a", a.out_p, e.p);
                if (chk_lat)
                    chk("lat_a", 32'(cyc - e.cyc), 32'd2);
            end
        end
        stall_prev = a.out_valid && !a.out_ready;
        prev_p     = a.out_p;
        if (b.in_valid && b.in_ready)
            qb.push_back('{b_exp, cyc});
        if (b.out_valid) begin
            n_cmp++;
            assert (qb.size() != 0)
            else begin
                n_bad++;
                $error("FAIL spurious_b obs=%h exp=none", b.out_p);
            end
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("data_b", b.out_p, e.p);
                chk("lat_b", 32'(cyc - e.cyc), 32'd2);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        a.in_valid  = 1'b0;
        b.in_valid  = 1'b0;
        a.out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (qa.size() == 0 && qb.size() == 0)
                break;
            cycle();
        end
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);
    endtask

    initial begin
        logic        z;
        logic [4:0]  k;
        logic [4:0]  f;
        logic        pend;
        int          sent;
        int          budget;

        a.in_valid  = 1'b0;
        a.in_zero   = 1'b0;
        a.in_k      = '0;
        a.in_f      = '0;
        a.out_ready = 1'b1;
        b.in_valid  = 1'b0;
        b.in_zero   = 1'b0;
        b.in_k      = '0;
        b.in_f      = '0;
        b.out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ovalid", 32'(a.out_valid), 32'd0);
        chk("rst_op", a.out_p, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_iready", 32'(a.in_ready), 32'd1);
        chk("rst_op_b", b.out_p, 32'd0);

        // directed vectors, both mantissa variants
        chk_lat = 1'b1;
        put_a(1'b0, 5'd10, 5'b00000, 32'd1040);
        put_b(5'd3, 5'b10000, 32'd12);
        cycle();
        chk("dir_acc0", 32'(acc), 32'd1);
        put_a(1'b0, 5'd3, 5'b10000, 32'd12);
        put_b(5'd0, 5'b11111, 32'd1);
        cycle();
        chk("dir_acc1", 32'(acc), 32'd1);
        put_a(1'b0, 5'd0, 5'b00000, 32'd1);
        put_b(5'd30, 5'b11111, 32'h7E000000);
        cycle();
        chk("dir_acc2", 32'(acc), 32'd1);
        put_a(1'b1, 5'd20, 5'b00000, 32'd0);
        b.in_valid = 1'b0;
        cycle();
        chk("dir_acc3", 32'(acc), 32'd1);
        drain();

        // back-to-back stream at full rate
        for (int i = 0; i < 64; i++) begin
            z = ($urandom_range(15) == 0);
            k = 5'($urandom_range(30));
            f = 5'($urandom_range(31));
            put_a(z, k, f, model(1, z, k, f));
            cycle();
            chk("stream_rdy", 32'(rdy), 32'd1);
        end
        drain();
        chk_lat = 1'b0;

        // backpressure: three items into a stalled pipe
        a.out_ready = 1'b0;
        put_a(1'b0, 5'd7, 5'd3, model(1, 1'b0, 5'd7, 5'd3));
        cycle();
        chk("bp_acc0", 32'(acc), 32'd1);
        put_a(1'b0, 5'd15, 5'd21, model(1, 1'b0, 5'd15, 5'd21));
        cycle();
        chk("bp_acc1", 32'(acc), 32'd1);
        put_a(1'b0, 5'd25, 5'd9, model(1, 1'b0, 5'd25, 5'd9));
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_full", 32'(rdy), 32'd0);
        end
        a.out_ready = 1'b1;
        cycle();
        chk("bp_acc2", 32'(acc), 32'd1);
        drain();

        // random traffic with random backpressure
        sent   = 0;
        pend   = 1'b0;
        budget = 0;
        while (sent < 1000 && budget < 20000) begin
            budget++;
            if (!pend) begin
                if ($urandom_range(9) < 7) begin
                    z = ($urandom_range(15) == 0);
                    k = 5'($urandom_range(30));
                    f = 5'($urandom_range(31));
                    put_a(z, k, f, model(1, z, k, f));
                    pend = 1'b1;
                end else begin
                    a.in_valid = 1'b0;
                end
            end
            a.out_ready = ($urandom_range(1) == 1);
            cycle();
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
        end
        chk("rand_sent", 32'(sent), 32'd1000);
        drain();

        // reset with two items in flight
        a.out_ready = 1'b0;
        put_a(1'b0, 5'd12, 5'd5, model(1, 1'b0, 5'd12, 5'd5));
        cycle();
        put_a(1'b0, 5'd18, 5'd30, model(1, 1'b0, 5'd18, 5'd30));
        cycle();
        chk("mid_full", 32'(a.out_valid), 32'd1);
        a.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_ovalid", 32'(a.out_valid), 32'd0);
        chk("mid_op", a.out_p, 32'd0);
        qa.delete();
        stall_prev = 1'b0;
        #1;
        rst_n = 1'b1;
        a.out_ready = 1'b1;
        repeat (3) cycle();
        chk_lat = 1'b1;
        put_a(1'b0, 5'd9, 5'd17, model(1, 1'b0, 5'd9, 5'd17));
        cycle();
        chk("post_acc", 32'(acc), 32'd1);
        drain();
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tblac_pipe.md
Name: tblac_pipe

Overview:
- Pipelined truncated binary-antilogarithm converter; the inverse of the truncated log converter in the approximate log multiplier datapath.
- Takes a summed truncated logarithm {k, f}, meaning characteristic k plus F-bit fraction f, and reconstructs the approximate linear product P = (1.f) * 2^k as a 32-bit integer.
- Sits after the log-domain adder and delivers products downstream over a valid/ready handshake.

Parameters:
- F, 5, fraction width of incoming log sum (16 minus truncation point M; M=11 gives 5).
- COMP, 1, 1 appends a constant '1' half-LSB compensation bit below f; 0 appends nothing.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input log sum valid.
- in_ready  output  1  block can accept input this cycle.
- in_zero  input  1  either multiplicand was zero; forces P=0.
- in_k  input  5  characteristic sum, legal 0..30.
- in_f  input  F  fraction sum; carry already folded into in_k.
- out_valid  output  1  out_p valid.
- out_ready  input  1  downstream accepts.
- out_p  output  32  approximate product.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_p=0, in_ready=1 after release. Reset mid-operation discards all in-flight items without producing output.
- Transfer in: occurs when in_valid and in_ready are both high at a clock edge. Transfer out: occurs when out_valid and out_ready are both high.
- Stage 1 (register):
  - Captures zero flag, k, and mantissa m = {1'b1, f, COMP bit}. Width W = F+1+COMP.
  - Precomputes shift amount s = k - (W-1) as signed 6-bit, plus direction flag left = (s >= 0).
- Stage 2 (register):
  - left: P = m << s.
  - else: P = m >> (-s), truncating the discarded bits (no rounding).
  - zero: P = 0.
  - Result zero-extended to 32 bits.
  - No overflow is possible for k <= 30 because P < 2^31. k=31 is illegal; the bench must not drive it, and the RTL is not required to saturate.
- Latency: exactly 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 item per cycle.
- Stall rules:
  - s2 advances (loads from s1) when !s2_valid or out_ready.
  - s1 advances when !s1_valid or s2 advances.
  - in_ready = !s1_valid || (!s2_valid || out_ready), a combinational function of registered state and out_ready only; no path from in_valid.
- Holding rules:
  - While out_valid=1 and out_ready=0, out_p and out_valid stay stable.
  - Stage 1 holds its data while stage 2 is stalled.
  - Pipeline holds 2 items maximum. When full and stalled, in_ready=0.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle with a full pipeline: both occur, no bubble, no drop, no duplication.
  - in_valid with in_ready=0: the input is ignored and the sender must hold it.
- Ordering: strict FIFO; no reordering.
- Bubbles: when s1 is empty, an advancing s2 loads with s2_valid=0. out_p contents while out_valid=0 are don't-care but must not be X after reset.

Test Plan:
- F=5, COMP=0, out_ready=1: k=3, f=5'b10000 -> out_p=12 exactly 2 cycles after acceptance; k=0, f=5'b11111 -> 1; k=30, f=5'b11111 -> 0x7E000000.
- F=5, COMP=1: k=10, f=0 -> 1040; k=3, f=5'b10000 -> 12 (truncated); k=0, f=0 -> 1; in_zero=1 with k=20 -> 0.
- Back-to-back stream of 64 random legal {k,f} with out_ready=1 -> in_ready constantly 1; outputs match reference model in order, one per cycle after a 2-cycle fill.
- Backpressure: out_ready=0 for 5 cycles while feeding 3 items -> first two accepted, in_ready=0 from the 3rd cycle, out_p stable; release -> items emerge in order with no loss or duplicate.
- Random out_ready (50%) and in_valid (70%) over 1000 items -> scoreboard match, no protocol violations (stable out_p during stall).
- Assert rst_n low mid-stream with 2 items in flight -> out_valid=0 and out_p=0 immediately (asynchronously); after release, the next input is produced correctly with 2-cycle latency and no stale output appears.
